// File: rtl/reg_writeback_ctrl.sv
// reg_writeback_ctrl: write-side initiator for the register file.
// It accepts ALU results and data-cache load results, and it holds the core
// while a cache miss is outstanding. It sign- or zero-extends sub-word loads,
// then drives the register file write port from registers one cycle later.
module reg_writeback_ctrl #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alu_valid,
    input  logic [REG_AW-1:0] alu_rd,
    input  logic [XLEN-1:0]   alu_result,
    input  logic              load_req,
    input  logic [REG_AW-1:0] load_rd,
    input  logic [2:0]        load_funct3,
    input  logic [1:0]        load_addr_lo,
    input  logic              mem_ready,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              stall_out,
    output logic              rf_write_en,
    output logic [REG_AW-1:0] rf_write_register,
    output logic [XLEN-1:0]   rf_write_data,
    output logic [CNT_W-1:0]  stall_cycles
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_MEM = 2'd1,
        WRITE    = 2'd2
    } state_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    state_t state, state_next;

    // Load parameters held while waiting for a cache miss to resolve
    logic [REG_AW-1:0] pend_rd;
    logic [2:0]        pend_funct3;
    logic [1:0]        pend_addr_lo;

    // Combinational decisions that the registers below consume
    logic              cap_en;
    logic [REG_AW-1:0] cap_rd;
    logic [XLEN-1:0]   cap_data;
    logic              pend_load;

    // The function selects a byte or halfword lane from the aligned word.
    // LB and LH sign-extend. LBU and LHU zero-extend. LW and unknown codes
    // pass the word through unchanged.
    function automatic logic [XLEN-1:0] extract_load(
        input logic [2:0]      f3,
        input logic [1:0]      lo,
        input logic [XLEN-1:0] word
    );
        logic [7:0]      b;
        logic [15:0]     h;
        logic [XLEN-1:0] r;
        b = word[8*lo +: 8];
        h = word[16*lo[1] +: 16];
        case (f3)
            F3_LB:   r = {{(XLEN-8){b[7]}}, b};
            F3_LBU:  r = {{(XLEN-8){1'b0}}, b};
            F3_LH:   r = {{(XLEN-16){h[15]}}, h};
            F3_LHU:  r = {{(XLEN-16){1'b0}}, h};
            F3_LW:   r = word;
            default: r = word;
        endcase
        return r;
    endfunction

    // State register; reset abandons any pending write
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next state and capture decisions. IDLE and WRITE accept new work identically.
    always_comb begin
        state_next = state;
        cap_en     = 1'b0;
        cap_rd     = '0;
        cap_data   = '0;
        pend_load  = 1'b0;
        case (state)
            IDLE, WRITE: begin
                state_next = IDLE;
                if (load_req) begin
                    if (mem_ready) begin
                        cap_en     = 1'b1;
                        cap_rd     = load_rd;
                        cap_data   = extract_load(load_funct3, load_addr_lo, mem_rdata);
                        state_next = WRITE;
                    end else begin
                        pend_load  = 1'b1;
                        state_next = WAIT_MEM;
                    end
                end else if (alu_valid) begin
                    cap_en     = 1'b1;
                    cap_rd     = alu_rd;
                    cap_data   = alu_result;
                    state_next = WRITE;
                end
            end
            WAIT_MEM: begin
                if (mem_ready) begin
                    cap_en     = 1'b1;
                    cap_rd     = pend_rd;
                    cap_data   = extract_load(pend_funct3, pend_addr_lo, mem_rdata);
                    state_next = WRITE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Stall while a miss is outstanding, including the cycle the miss is first seen
    always_comb begin
        stall_out = (state == WAIT_MEM) ||
                    ((state == IDLE || state == WRITE) && load_req && !mem_ready);
    end

    // Hold the load parameters of a missed load until the cache answers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_rd      <= '0;
            pend_funct3  <= '0;
            pend_addr_lo <= '0;
        end else if (pend_load) begin
            pend_rd      <= load_rd;
            pend_funct3  <= load_funct3;
            pend_addr_lo <= load_addr_lo;
        end
    end

    // Register the write port. Writes to x0 are suppressed, and address and data
    // keep their last values whenever no write is issued.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rf_write_en       <= 1'b0;
            rf_write_register <= '0;
            rf_write_data     <= '0;
        end else begin
            rf_write_en <= cap_en && (cap_rd != '0);
            if (cap_en && (cap_rd != '0)) begin
                rf_write_register <= cap_rd;
                rf_write_data     <= cap_data;
            end
        end
    end

    // Count the cycles spent in WAIT_MEM, saturating at all-ones
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            stall_cycles <= '0;
        else if (state == WAIT_MEM && stall_cycles != {CNT_W{1'b1}})
            stall_cycles <= stall_cycles + 1'b1;
    end

endmodule

// File: tb/tb_reg_writeback_ctrl.sv
// tb_reg_writeback_ctrl: self-checking bench for reg_writeback_ctrl.
// A vector table covers single-cycle ALU writes and load hits. Hand-written
// sequences cover a miss, back-to-back writes, and reset during a miss. A
// scoreboard queue holds the expected register writes in order.
module tb_reg_writeback_ctrl;

    logic        clk;
    logic        reset;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_result;
    logic        load_req;
    logic [4:0]  load_rd;
    logic [2:0]  load_funct3;
    logic [1:0]  load_addr_lo;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        stall_out;
    logic        rf_write_en;
    logic [4:0]  rf_write_register;
    logic [31:0] rf_write_data;
    logic [15:0] stall_cycles;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    exp_t sb_q[$];

    typedef struct {
        logic        alu_valid;
        logic [4:0]  alu_rd;
        logic [31:0] alu_result;
        logic        load_req;
        logic [4:0]  load_rd;
        logic [2:0]  funct3;
        logic [1:0]  addr_lo;
        logic        mem_ready;
        logic [31:0] mem_rdata;
        logic        exp_write;
        logic [4:0]  exp_rd;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[13];

    reg_writeback_ctrl #(.XLEN(32), .REG_AW(5), .CNT_W(16)) dut (
        .clk               (clk),
        .reset             (reset),
        .alu_valid         (alu_valid),
        .alu_rd            (alu_rd),
        .alu_result        (alu_result),
        .load_req          (load_req),
        .load_rd           (load_rd),
        .load_funct3       (load_funct3),
        .load_addr_lo      (load_addr_lo),
        .mem_ready         (mem_ready),
        .mem_rdata         (mem_rdata),
        .stall_out         (stall_out),
        .rf_write_en       (rf_write_en),
        .rf_write_register (rf_write_register),
        .rf_write_data     (rf_write_data),
        .stall_cycles      (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        alu_valid    = 1'b0;
        alu_rd       = '0;
        alu_result   = '0;
        load_req     = 1'b0;
        load_rd      = '0;
        load_funct3  = '0;
        load_addr_lo = '0;
        mem_ready    = 1'b0;
        mem_rdata    = '0;
    endtask

    task automatic apply_stimulus(input vec_t v);
        alu_valid    = v.alu_valid;
        alu_rd       = v.alu_rd;
        alu_result   = v.alu_result;
        load_req     = v.load_req;
        load_rd      = v.load_rd;
        load_funct3  = v.funct3;
        load_addr_lo = v.addr_lo;
        mem_ready    = v.mem_ready;
        mem_rdata    = v.mem_rdata;
    endtask

    task automatic expect_write(input logic [4:0] rd, input logic [31:0] data);
        exp_t e;
        e.rd   = rd;
        e.data = data;
        sb_q.push_back(e);
    endtask

    // At the negative edge, compare any write-port pulse against the scoreboard head
    task automatic sample();
        exp_t e;
        @(negedge clk);
        if (!reset && rf_write_en === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_write actual=reg%0d/0x%08h expected=none",
                         rf_write_register, rf_write_data);
            end else begin
                e = sb_q.pop_front();
                check_output("write_reg", {27'd0, rf_write_register}, {27'd0, e.rd});
                check_output("write_data", rf_write_data, e.data);
            end
        end
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Single-cycle vectors. A write is expected the cycle after the vector is applied.
        vecs[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  3'b000, 2'd0, 1'b0, 32'h0,        1'b1, 5'd5,  32'hDEADBEEF};
        vecs[1]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  3'b000, 2'd2, 1'b1, 32'h12F03456, 1'b1, 5'd7,  32'hFFFFFFF0};
        vecs[2]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  3'b100, 2'd2, 1'b1, 32'h12F03456, 1'b1, 5'd7,  32'h000000F0};
        vecs[3]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd8,  3'b001, 2'd0, 1'b1, 32'h12F03456, 1'b1, 5'd8,  32'h00003456};
        vecs[4]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd10, 3'b001, 2'd3, 1'b1, 32'h80017FFF, 1'b1, 5'd10, 32'hFFFF8001};
        vecs[5]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd11, 3'b101, 2'd2, 1'b1, 32'h80010000, 1'b1, 5'd11, 32'h00008001};
        vecs[6]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd12, 3'b010, 2'd1, 1'b1, 32'hCAFEF00D, 1'b1, 5'd12, 32'hCAFEF00D};
        vecs[7]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd13, 3'b011, 2'd3, 1'b1, 32'h0BADF00D, 1'b1, 5'd13, 32'h0BADF00D};
        vecs[8]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd14, 3'b000, 2'd0, 1'b1, 32'h0000007F, 1'b1, 5'd14, 32'h0000007F};
        vecs[9]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd15, 3'b000, 2'd3, 1'b1, 32'h80000000, 1'b1, 5'd15, 32'hFFFFFF80};
        vecs[10] = '{1'b1, 5'd0,  32'h00001234, 1'b0, 5'd0,  3'b000, 2'd0, 1'b0, 32'h0,        1'b0, 5'd15, 32'hFFFFFF80};
        vecs[11] = '{1'b1, 5'd4,  32'h44444444, 1'b1, 5'd3,  3'b010, 2'd0, 1'b1, 32'h33333333, 1'b1, 5'd3,  32'h33333333};
        vecs[12] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd9,  3'b010, 2'd0, 1'b1, 32'h55555555, 1'b0, 5'd3,  32'h33333333};

        drive_idle();
        reset = 1'b1;
        advance();
        advance();
        sample();
        check_output("reset_write_en", {31'd0, rf_write_en}, 32'd0);
        check_output("reset_write_reg", {27'd0, rf_write_register}, 32'd0);
        check_output("reset_write_data", rf_write_data, 32'd0);
        check_output("reset_stall_cycles", {16'd0, stall_cycles}, 32'd0);
        check_output("reset_stall_out", {31'd0, stall_out}, 32'd0);
        advance();
        reset = 1'b0;
        advance();

        // Table: apply one vector, then spend one idle cycle and observe the write
        for (int i = 0; i < 13; i++) begin
            apply_stimulus(vecs[i]);
            if (vecs[i].exp_write) expect_write(vecs[i].exp_rd, vecs[i].exp_data);
            sample();
            check_output($sformatf("vec%0d_stall", i), {31'd0, stall_out}, 32'd0);
            check_output($sformatf("vec%0d_en_before", i), {31'd0, rf_write_en}, 32'd0);
            advance();
            drive_idle();
            sample();
            check_output($sformatf("vec%0d_en", i), {31'd0, rf_write_en}, {31'd0, vecs[i].exp_write});
            check_output($sformatf("vec%0d_hold_reg", i), {27'd0, rf_write_register}, {27'd0, vecs[i].exp_rd});
            check_output($sformatf("vec%0d_hold_data", i), rf_write_data, vecs[i].exp_data);
            advance();
        end

        // Miss: LH at offset 2 to rd 9. The cache answers after four low cycles.
        drive_idle();
        load_req = 1'b1; load_rd = 5'd9; load_funct3 = 3'b001; load_addr_lo = 2'd2;
        sample();
        check_output("miss_stall_first", {31'd0, stall_out}, 32'd1);
        advance();
        drive_idle();
        alu_valid = 1'b1; alu_rd = 5'd20; alu_result = 32'h77777777;
        for (int c = 0; c < 3; c++) begin
            sample();
            check_output($sformatf("miss_stall_wait%0d", c), {31'd0, stall_out}, 32'd1);
            check_output($sformatf("miss_en_wait%0d", c), {31'd0, rf_write_en}, 32'd0);
            advance();
        end
        drive_idle();
        mem_ready = 1'b1; mem_rdata = 32'h80010000;
        expect_write(5'd9, 32'hFFFF8001);
        sample();
        check_output("miss_stall_ready", {31'd0, stall_out}, 32'd1);
        check_output("miss_en_ready", {31'd0, rf_write_en}, 32'd0);
        advance();
        drive_idle();
        sample();
        check_output("miss_en_write", {31'd0, rf_write_en}, 32'd1);
        check_output("miss_stall_write", {31'd0, stall_out}, 32'd0);
        check_output("miss_stall_cycles", {16'd0, stall_cycles}, 32'd4);
        advance();
        sample();
        check_output("miss_en_after", {31'd0, rf_write_en}, 32'd0);
        advance();

        // Back-to-back ALU results to rd 1, 2 and 3, each written on consecutive cycles
        for (int k = 1; k <= 3; k++) begin
            drive_idle();
            alu_valid = 1'b1; alu_rd = 5'(k); alu_result = 32'hA0000000 + 32'(k);
            expect_write(5'(k), 32'hA0000000 + 32'(k));
            sample();
            check_output($sformatf("b2b_en_cycle%0d", k), {31'd0, rf_write_en}, (k == 1) ? 32'd0 : 32'd1);
            advance();
        end
        drive_idle();
        sample();
        check_output("b2b_en_last", {31'd0, rf_write_en}, 32'd1);
        advance();
        sample();
        check_output("b2b_en_done", {31'd0, rf_write_en}, 32'd0);
        advance();

        // Reset during WAIT_MEM: the pending load must never be written
        load_req = 1'b1; load_rd = 5'd21; load_funct3 = 3'b010;
        sample();
        advance();
        drive_idle();
        sample();
        check_output("rst_wait_stall", {31'd0, stall_out}, 32'd1);
        reset = 1'b1;
        #1;
        check_output("rst_en", {31'd0, rf_write_en}, 32'd0);
        check_output("rst_reg", {27'd0, rf_write_register}, 32'd0);
        check_output("rst_data", rf_write_data, 32'd0);
        check_output("rst_stall_cycles", {16'd0, stall_cycles}, 32'd0);
        check_output("rst_stall_out", {31'd0, stall_out}, 32'd0);
        advance();
        reset = 1'b0;
        mem_ready = 1'b1; mem_rdata = 32'h99999999;
        sample();
        check_output("rst_ready_stall", {31'd0, stall_out}, 32'd0);
        advance();
        drive_idle();
        sample();
        check_output("rst_no_write", {31'd0, rf_write_en}, 32'd0);
        check_output("rst_reg_after", {27'd0, rf_write_register}, 32'd0);
        advance();
        sample();
        check_output("rst_no_write2", {31'd0, rf_write_en}, 32'd0);

        check_output("scoreboard_empty", sb_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_writeback_ctrl.md
Name: reg_writeback_ctrl

Overview:
- Write-side initiator for the register file.
- Collects results from the single-cycle datapath: ALU results arrive directly, load results arrive from the data cache.
- Drives the register file write port (write_register, write_data, write_en) one cycle later from registers.
- Holds the core via stall_out while a cache miss is outstanding.
- Extracts and sign- or zero-extends sub-word load data.

Parameters:
- XLEN, 32, data width of results and register file.
- REG_AW, 5, register address width.
- CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- alu_valid  input  1  ALU result valid this cycle.
- alu_rd  input  REG_AW  ALU destination register.
- alu_result  input  XLEN  ALU result.
- load_req  input  1  load issued this cycle.
- load_rd  input  REG_AW  load destination register.
- load_funct3  input  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- load_addr_lo  input  2  byte offset of the load address.
- mem_ready  input  1  cache data valid.
- mem_rdata  input  XLEN  aligned 32-bit word from the cache.
- stall_out  output  1  freeze the core PC and pipeline.
- rf_write_en  output  1  register file write enable.
- rf_write_register  output  REG_AW  register file write address.
- rf_write_data  output  XLEN  register file write data.
- stall_cycles  output  CNT_W  saturating count of cycles spent in WAIT_MEM.

Behaviour:
- Reset is asynchronous, active-high, clock is clk.
- Reset values: state IDLE; rf_write_en 0; rf_write_register 0; rf_write_data 0; stall_cycles 0; pending rd/funct3/addr_lo registers 0.
- States: IDLE, WAIT_MEM, WRITE.
- IDLE, load_req=1 and mem_ready=1 (cache hit):
  - Capture extracted data and load_rd.
  - Go to WRITE.
  - No stall.
- IDLE, load_req=1 and mem_ready=0 (miss):
  - Capture load_rd, load_funct3, load_addr_lo.
  - Go to WAIT_MEM.
- IDLE, alu_valid=1 and load_req=0:
  - Capture alu_rd and alu_result.
  - Go to WRITE.
- IDLE, load_req=1 and alu_valid=1 together: load wins, ALU input is dropped.
- IDLE, mem_ready=1 without load_req: ignored.
- WAIT_MEM:
  - Stay until mem_ready=1, then capture extracted data from the held funct3/addr_lo and go to WRITE.
  - alu_valid and load_req are ignored.
  - stall_cycles increments every cycle here and saturates at all-ones.
- WRITE:
  - rf_write_en=1 for exactly one cycle with the captured rd and data.
  - Next state is IDLE.
  - A new alu_valid or load_req arriving in WRITE is accepted exactly as in IDLE and may chain directly into WRITE or WAIT_MEM (back-to-back writes, no bubble).
- rd=0: rf_write_en forced 0 in WRITE; the state sequence is unchanged.
- stall_out is combinational: (state==WAIT_MEM) OR (state in {IDLE, WRITE} AND load_req AND NOT mem_ready).
- Latency: rf_write_en asserts the cycle after acceptance (ALU result or load hit), or the cycle after mem_ready (miss).
- Extraction:
  - LB/LBU use byte mem_rdata[8*addr_lo +: 8].
  - LH/LHU use halfword mem_rdata[16*addr_lo[1] +: 16]; addr_lo[0] is ignored.
  - LB/LH sign-extend to XLEN; LBU/LHU zero-extend.
  - LW and all undefined funct3 codes pass the word through unchanged.
- Reset during WAIT_MEM or WRITE: the pending write is abandoned and no rf_write_en pulse is issued after reset release.
- rf_write_register and rf_write_data hold their last values when rf_write_en=0.

Test Plan:
- Reset, then alu_valid=1, rd=5, result=0xDEADBEEF -> next cycle rf_write_en=1, reg 5, data 0xDEADBEEF, stall_out=0 throughout.
- load_req=1, LB, addr_lo=2, rd=7, mem_ready=1 same cycle, mem_rdata=0x12F03456 -> next cycle write reg 7 data 0xFFFFFFF0; LBU same stimulus -> 0x000000F0.
- load_req=1, LH, addr_lo=2, rd=9, mem_ready held low 4 cycles then 1 with mem_rdata=0x80010000 -> stall_out high those 4 cycles, stall_cycles=4, following cycle writes reg 9 data 0xFFFF8001.
- alu_valid=1, rd=0, result=0x1234 -> passes through WRITE with rf_write_en=0; then load_req and alu_valid together (rd 3 vs rd 4, hit) -> only reg 3 written.
- Miss in progress (WAIT_MEM), assert reset for 1 cycle, then mem_ready=1 -> no write, outputs zero, state IDLE.
- Back-to-back alu_valid on 3 consecutive cycles, rd 1, 2, 3 -> rf_write_en high 3 consecutive cycles with matching address and data.
